// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and helpers for the hpdcache SRAM controller.
// Used by both default and HPDCACHE_SRAM_CTRL_INIT_EN builds.
package hpdcache_sram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Requester-id width; a single bit is kept even for two requesters.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_sram_ctrl_rrarb.sv
// Round-robin one-hot picker: rotate requests by the pointer, take the lowest,
// rotate back. The pointer moves just past each winner.
module hpdcache_sram_ctrl_rrarb
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt
);

  localparam int PW = id_width(NREQ);

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_win;
  logic [2*NREQ-1:0] w_req2;
  logic [2*NREQ-1:0] w_unrot;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_pick;

  assign w_req2 = {i_req, i_req};
  assign w_rot  = NREQ'(w_req2 >> r_ptr);

  // Lowest set bit of the rotated vector has priority.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pick
    localparam logic [NREQ-1:0] LOWER = NREQ'((1 << gi) - 1);
    assign w_pick[gi] = w_rot[gi] & ~|(w_rot & LOWER);
  end

  assign w_unrot = {w_pick, w_pick} << r_ptr;
  assign o_gnt   = NREQ'(w_unrot >> NREQ);

  always_comb begin
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (o_gnt[k]) w_win = PW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
    end
  end

endmodule

// File: rtl/hpdcache_sram_ctrl.sv
// Shares one 1RW hpdcache SRAM among NREQ requesters with a 1-entry read hold buffer.
// Optional macro HPDCACHE_SRAM_CTRL_INIT_EN zero-fills the SRAM after reset.
module hpdcache_sram_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDR_SIZE = 6,
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 2**ADDR_SIZE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                i_req_valid,
  output logic [NREQ-1:0]                o_req_ready,
  input  logic [NREQ-1:0]                i_req_we,
  input  logic [NREQ*ADDR_SIZE-1:0]      i_req_addr,
  input  logic [NREQ*DATA_SIZE-1:0]      i_req_wdata,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [id_width(NREQ)-1:0]      o_rsp_id,
  output logic [DATA_SIZE-1:0]           o_rsp_rdata,
  output logic                           o_init_done,
  output logic                           o_sram_cs,
  output logic                           o_sram_we,
  output logic [ADDR_SIZE-1:0]           o_sram_addr,
  output logic [DATA_SIZE-1:0]           o_sram_wdata,
  input  logic [DATA_SIZE-1:0]           i_sram_rdata
);

  localparam int IDW = id_width(NREQ);

  logic                 w_init_wr;
  logic [ADDR_SIZE-1:0] w_init_addr;
  logic                 r_init_done;

  logic                 r_rsp_valid;
  logic [IDW-1:0]       r_rsp_id;
  logic                 r_held;
  logic [DATA_SIZE-1:0] r_hold;

  logic                 w_rsp_blocked;
  logic                 w_rd_acc;
  logic [NREQ-1:0]      w_eligible;
  logic [NREQ-1:0]      w_gnt;
  logic [ADDR_SIZE-1:0] w_addr_arr  [NREQ];
  logic [DATA_SIZE-1:0] w_wdata_arr [NREQ];
  logic [IDW-1:0]       w_win_id;
  logic                 w_win_we;
  logic [ADDR_SIZE-1:0] w_win_addr;
  logic [DATA_SIZE-1:0] w_win_wdata;

  assign w_rsp_blocked = r_rsp_valid & ~i_rsp_ready;

  // A stalled response blocks reads only; writes never touch the hold buffer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_addr_arr[gi]  = i_req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
    assign w_wdata_arr[gi] = i_req_wdata[gi*DATA_SIZE +: DATA_SIZE];
    assign w_eligible[gi]  = i_req_valid[gi] & r_init_done & ~(~i_req_we[gi] & w_rsp_blocked);
  end

  hpdcache_sram_ctrl_rrarb #(
    .NREQ (NREQ)
  ) u_rrarb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_eligible),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_win_id    = '0;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_win_id    = IDW'(k);
        w_win_we    = i_req_we[k];
        w_win_addr  = w_addr_arr[k];
        w_win_wdata = w_wdata_arr[k];
      end
    end
  end

  assign w_rd_acc = (|w_gnt) & ~w_win_we;

`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
  localparam logic [ADDR_SIZE:0] LAST_ADDR = (ADDR_SIZE+1)'(DEPTH - 1);

  ctrl_state_e          r_state;
  logic [ADDR_SIZE:0]   r_cnt;
  logic                 r_init_wr;

  // The first cycle after reset arms the write strobe, then one zero write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_wr   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_wr <= 1'b1;
          if (r_init_wr) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
              r_state     <= ST_RUN;
              r_init_wr   <= 1'b0;
              r_init_done <= 1'b1;
            end
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign w_init_wr   = r_init_wr;
  assign w_init_addr = r_cnt[ADDR_SIZE-1:0];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init_done <= 1'b0;
    else        r_init_done <= 1'b1;
  end

  assign w_init_wr   = 1'b0;
  assign w_init_addr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_held      <= 1'b0;
      r_hold      <= '0;
    end else begin
      if (w_rd_acc) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_win_id;
        r_held      <= 1'b0;
      end else if (r_rsp_valid && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_held      <= 1'b0;
      end
      // SRAM output is only trustworthy the cycle after the read; latch it on stall.
      if (w_rsp_blocked && !r_held) begin
        r_hold <= i_sram_rdata;
        r_held <= 1'b1;
      end
    end
  end

  assign o_req_ready  = w_gnt;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_rdata  = !r_rsp_valid ? '0 : (r_held ? r_hold : i_sram_rdata);
  assign o_init_done  = r_init_done;
  assign o_sram_cs    = w_init_wr | (|w_gnt);
  assign o_sram_we    = w_init_wr | w_win_we;
  assign o_sram_addr  = w_init_wr ? w_init_addr : w_win_addr;
  assign o_sram_wdata = w_init_wr ? '0 : w_win_wdata;

endmodule

// File: tb/tb_hpdcache_sram_ctrl.sv
// Directed bench for hpdcache_sram_ctrl (NREQ=3, ADDR_SIZE=4, DATA_SIZE=16).
// Follows HPDCACHE_SRAM_CTRL_INIT_EN when the build defines it.
module tb_hpdcache_sram_ctrl;

  localparam int NREQ  = 3;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_rdata;
  logic               init_done, sram_cs, sram_we;
  logic [AW-1:0]      sram_addr;
  logic [DW-1:0]      sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  hpdcache_sram_ctrl #(
    .NREQ(NREQ), .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_rdata  (rsp_rdata),
    .o_init_done  (init_done),
    .o_sram_cs    (sram_cs),
    .o_sram_we    (sram_we),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata)
  );

  // 1RW SRAM model; its output is garbage after a write cycle.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        sram_rdata     <= 16'hDEAD;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic all_reads();
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
  endtask

  // Called at the negedge where rst_n was just released.
  task automatic wait_init(input string tag);
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) clear_reqs();
      #1;
      checks++;
      if (sram_cs !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(i) || sram_wdata !== '0 ||
          init_done !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL %s_init_wr%0d cs=%b we=%b addr=%0d wdata=%h done=%b ready=%b, expected 1 1 %0d 0000 0 000",
                 tag, i, sram_cs, sram_we, sram_addr, sram_wdata, init_done, req_ready, i);
      end
      @(negedge clk);
    end
`else
    @(negedge clk);
    clear_reqs();
`endif
    #1;
    checks++;
    if (init_done !== 1'b1 || sram_cs !== 1'b0) begin
      errors++;
      $display("FAIL %s_init_done got done=%b cs=%b, expected done=1 cs=0", tag, init_done, sram_cs);
    end
  endtask

  task automatic test_reset();
    all_reads();
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b expected 000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d expected 0", rsp_id); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h expected 0000", rsp_rdata); end
    checks++; if (sram_cs !== 1'b0) begin errors++; $display("FAIL reset_sram_cs got %b expected 0", sram_cs); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b expected 0", init_done); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reset");
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_gnt [4];
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      all_reads();
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp_gnt[c]) begin
        errors++; $display("FAIL contention_gnt%0d got %b expected %b", c, req_ready, exp_gnt[c]);
      end
      checks++;
      if (c == 0) begin
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL contention_rsp%0d valid=%b expected 0", c, rsp_valid); end
      end else if (rsp_valid !== 1'b1 || rsp_id !== IDW'(c - 1)) begin
        errors++; $display("FAIL contention_rsp%0d valid=%b id=%0d expected 1 %0d", c, rsp_valid, rsp_id, c - 1);
      end
    end
    @(negedge clk); clear_reqs(); #1;
    checks++;
    if (req_ready !== 3'b000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL contention_last ready=%b valid=%b id=%0d expected 000 1 0", req_ready, rsp_valid, rsp_id);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL contention_drain valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_read_after_write();
    @(negedge clk); clear_reqs(); set_req(0, 1'b1, 4'd3, 16'h00A5); #1;
    checks++;
    if (req_ready !== 3'b001 || sram_we !== 1'b1 || sram_addr !== 4'd3 || sram_wdata !== 16'h00A5) begin
      errors++; $display("FAIL raw_write ready=%b we=%b addr=%0d wdata=%h expected 001 1 3 00a5", req_ready, sram_we, sram_addr, sram_wdata);
    end
    @(negedge clk); clear_reqs(); set_req(1, 1'b0, 4'd3, '0); #1;
    checks++;
    if (req_ready !== 3'b010 || sram_we !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL raw_read ready=%b we=%b rsp_valid=%b expected 010 0 0", req_ready, sram_we, rsp_valid);
    end
    @(negedge clk); clear_reqs(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_rdata !== 16'h00A5) begin
      errors++; $display("FAIL raw_rsp valid=%b id=%0d rdata=%h expected 1 1 00a5", rsp_valid, rsp_id, rsp_rdata);
    end
  endtask

  task automatic test_stall();
    @(negedge clk); clear_reqs(); rsp_ready = 1'b1; set_req(0, 1'b1, 4'd5, 16'h1234); #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL stall_setup_wr ready=%b expected 001", req_ready); end
    @(negedge clk); clear_reqs(); set_req(2, 1'b0, 4'd5, '0); #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL stall_rd ready=%b expected 100", req_ready); end
    // First stall cycle: read blocked, same-address write still granted.
    @(negedge clk); clear_reqs(); rsp_ready = 1'b0;
    set_req(0, 1'b0, 4'd5, '0); set_req(1, 1'b1, 4'd5, 16'hBEEF); #1;
    checks++;
    if (req_ready !== 3'b010 || sram_we !== 1'b1 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rdata !== 16'h1234) begin
      errors++; $display("FAIL stall_c0 ready=%b we=%b valid=%b id=%0d rdata=%h expected 010 1 1 2 1234",
                         req_ready, sram_we, rsp_valid, rsp_id, rsp_rdata);
    end
    for (int c = 1; c < 3; c++) begin
      @(negedge clk); clear_reqs(); set_req(0, 1'b0, 4'd5, '0); #1;
      checks++;
      if (req_ready !== 3'b000 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rdata !== 16'h1234) begin
        errors++; $display("FAIL stall_c%0d ready=%b valid=%b id=%0d rdata=%h expected 000 1 2 1234",
                           c, req_ready, rsp_valid, rsp_id, rsp_rdata);
      end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    checks++;
    if (req_ready !== 3'b001 || rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin
      errors++; $display("FAIL stall_release ready=%b valid=%b rdata=%h expected 001 1 1234", req_ready, rsp_valid, rsp_rdata);
    end
    @(negedge clk); clear_reqs(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL stall_next_rsp valid=%b id=%0d rdata=%h expected 1 0 beef", rsp_valid, rsp_id, rsp_rdata);
    end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] pat [4];
    pat = '{16'h0000, 16'h0111, 16'h0222, 16'h0333};
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); clear_reqs(); set_req(0, 1'b1, AW'(i), pat[i]); #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL b2b_wr%0d ready=%b expected 001", i, req_ready); end
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); clear_reqs();
      if (i < 4) set_req(0, 1'b0, AW'(i), '0);
      #1;
      if (i < 4) begin
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL b2b_rd%0d ready=%b expected 001", i, req_ready); end
      end
      if (i > 1) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rdata !== pat[i-1]) begin
          errors++; $display("FAIL b2b_rsp%0d valid=%b id=%0d rdata=%h expected 1 0 %h", i - 1, rsp_valid, rsp_id, rsp_rdata, pat[i-1]);
        end
      end
    end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_stall();
    logic [DW-1:0] exp_data;
`ifdef HPDCACHE_SRAM_CTRL_INIT_EN
    exp_data = 16'h0000;
`else
    exp_data = 16'h0222;
`endif
    @(negedge clk); clear_reqs(); rsp_ready = 1'b1; set_req(1, 1'b0, 4'd2, '0); #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rst_rd ready=%b expected 010", req_ready); end
    @(negedge clk); clear_reqs(); rsp_ready = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0222) begin
      errors++; $display("FAIL rst_pre valid=%b rdata=%h expected 1 0222", rsp_valid, rsp_rdata);
    end
    #2; all_reads(); rst_n = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 3'b000 || sram_cs !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 16'h0) begin
      errors++; $display("FAIL rst_async valid=%b ready=%b cs=%b done=%b rdata=%h expected 0 000 0 0 0000",
                         rsp_valid, req_ready, sram_cs, init_done, rsp_rdata);
    end
    @(negedge clk); rsp_ready = 1'b1; rst_n = 1'b1;
    wait_init("rst_again");
    @(negedge clk); all_reads(); req_addr = {4'd2, 4'd2, 4'd2}; #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rst_ptr ready=%b expected 001", req_ready); end
    @(negedge clk); clear_reqs(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rdata !== exp_data) begin
      errors++; $display("FAIL rst_post_rsp valid=%b id=%0d rdata=%h expected 1 0 %h", rsp_valid, rsp_id, rsp_rdata, exp_data);
    end
  endtask

  initial begin
    clear_reqs();
    rsp_ready = 1'b1;
    test_reset();
    test_contention();
    test_read_after_write();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
